ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. It is the counterpart of the keyboard scan-code receiver on the same ps2_clk/ps2_data pins.
- Sends one command byte per request to the keyboard, e.g. 0xED for set-LEDs or 0xFF for reset. It generates the inhibit/request-to-send sequence, shifts out data, parity and stop on device-generated clock edges, and checks the device ack bit.
- Drives the pins open-drain through active-high "pull low" enables. The top level builds the tri-states.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_edge_sync.sv | 34 +++
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, keyboard command
// and reply bytes, and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    WAIT_START,
    DATA,
    WAIT_IDLE,
    ABORT
  } state_t;

  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  // Bit index after fall #1 is 0; these mark which fall comes next.
  localparam logic [3:0] IDX_PARITY = 4'd7;
  localparam logic [3:0] IDX_STOP   = 4'd8;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus a one-cycle
// pulse on each synchronized falling edge of the PS/2 clock.
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_s,
  output logic o_data_s,
  output logic o_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;

  // NOTE: sync flops reset to 1 (idle bus) so leaving reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign o_clk_s  = r_clk_sync[1];
  assign o_data_s = r_data_sync[1];
  assign o_fall   = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift out one
// command byte on device clock falls, check the ack, and flag timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int FRAME_TIMEOUT  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err
);
  import ps2_pkg::*;

  localparam int CNT_MAX0 = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > FRAME_TIMEOUT) ? CNT_MAX0 : FRAME_TIMEOUT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [3:0]       r_idx, w_idx;
  logic [7:0]       r_shift, w_shift;
  logic             r_parity, w_parity;
  logic             r_clk_oe, w_clk_oe;
  logic             r_data_oe, w_data_oe;
  logic             r_done, w_done;
  logic             r_err, w_err;
  logic             w_abort;
  logic             w_clk_s, w_data_s, w_fall;

  ps2_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_clk_s    (w_clk_s),
    .o_data_s   (w_data_s),
    .o_fall     (w_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_idx     <= w_idx;
      r_shift   <= w_shift;
      r_parity  <= w_parity;
      r_clk_oe  <= w_clk_oe;
      r_data_oe <= w_data_oe;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  // NOTE: every next-value gets a default first so no branch infers a latch.
  always_comb begin
    w_state   = r_state;
    w_cnt     = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    w_idx     = r_idx;
    w_shift   = r_shift;
    w_parity  = r_parity;
    w_clk_oe  = r_clk_oe;
    w_data_oe = r_data_oe;
    w_done    = 1'b0;
    w_err     = 1'b0;
    w_abort   = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt     = '0;
        w_clk_oe  = 1'b0;
        w_data_oe = 1'b0;
        if (tx_valid) begin
          w_shift  = tx_data;
          w_parity = odd_parity(tx_data);
          w_clk_oe = 1'b1;
          w_state  = INHIBIT;
        end
      end
      INHIBIT: begin
        // Data goes low one cycle before the clock is released.
        if (r_data_oe) begin
          w_clk_oe = 1'b0;
          w_cnt    = '0;
          w_state  = WAIT_START;
        end else if (r_cnt == INH_LAST) begin
          w_data_oe = 1'b1;
        end
      end
      WAIT_START: begin
        if (r_cnt == START_LAST) begin
          w_abort = 1'b1;
        end else if (w_fall) begin
          w_cnt     = '0;
          w_idx     = '0;
          w_data_oe = ~r_shift[0];
          w_shift   = {1'b0, r_shift[7:1]};
          w_state   = DATA;
        end
      end
      DATA: begin
        if (r_cnt == FRAME_LAST) begin
          w_abort = 1'b1;
        end else if (w_fall) begin
          w_idx = r_idx + 1'b1;
          if (r_idx < IDX_PARITY) begin
            w_data_oe = ~r_shift[0];
            w_shift   = {1'b0, r_shift[7:1]};
          end else if (r_idx == IDX_PARITY) begin
            w_data_oe = ~r_parity;
          end else if (r_idx == IDX_STOP) begin
            w_data_oe = 1'b0;
          end else if (w_data_s) begin
            w_abort = 1'b1;
          end else begin
            w_state = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (r_cnt == FRAME_LAST) begin
          w_abort = 1'b1;
        end else if (w_clk_s && w_data_s) begin
          w_done  = 1'b1;
          w_state = IDLE;
        end
      end
      ABORT: begin
        w_clk_oe  = 1'b0;
        w_data_oe = 1'b0;
        w_state   = IDLE;
      end
      default: w_state = IDLE;
    endcase

    if (w_abort) begin
      w_state   = ABORT;
      w_clk_oe  = 1'b0;
      w_data_oe = 1'b0;
      w_err     = 1'b1;
    end
  end

  assign tx_ready    = (r_state == IDLE);
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on open-drain pins clocks frames
// out of the host, and received bits are compared with a frame model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 50;
  localparam int STO = 200;
  localparam int FTO = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, done, err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk, ps2_data;

  int n_cmp = 0, n_fail = 0;
  int n_done = 0, n_err = 0, n_both = 0, n_err_oe = 0;

  assign ps2_clk  = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .FRAME_TIMEOUT  (FTO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .err         (err)
  );

  always @(negedge clk) begin
    if (done) n_done++;
    if (err) n_err++;
    if (done && err) n_both++;
    if (err && (ps2_clk_oe || ps2_data_oe)) n_err_oe++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bits a device reads on rises 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = ((int'(d) >> i) % 2) == 1;
    f[8] = ($countones(d) % 2) == 0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic dev_frame(input int n_falls, input bit ack, input bit drop_valid, input int half,
                           output logic [9:0] rx, output int inh, output int both,
                           output logic start_lvl, output bit tmo);
    int k;
    rx = '1; inh = 0; both = 0; start_lvl = 1'b1; tmo = 1'b0; k = 0;
    while (!ps2_clk_oe && k < 100) begin step(1); k++; end
    if (!ps2_clk_oe) begin tmo = 1'b1; return; end
    if (drop_valid) tx_valid = 1'b0;
    while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin inh++; step(1); end
    while (ps2_clk_oe && ps2_data_oe && both < 1000) begin both++; step(1); end
    start_lvl = ps2_data;
    if (n_falls == 0) return;
    step($urandom_range(5, 30));
    for (int n = 1; n <= n_falls; n++) begin
      if (n == 11 && ack) begin dev_data = 1'b0; step(2); end
      dev_clk = 1'b0;
      step(half);
      dev_clk = 1'b1;
      if (n <= 10) rx[n-1] = ps2_data;
      step(half);
    end
    dev_data = 1'b1;
  endtask

  initial begin
    logic [9:0] rx, rx2;
    int         inh, both, d0, e0, k, half;
    logic       sl;
    bit         tmo;
    logic [7:0] b;

    rst = 1'b1;
    step(3);
    check("rst_ready", tx_ready, 1);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_done_err", {done, err}, 0);
    rst = 1'b0;
    step(2);

    // Set-LED command with a well-behaved device.
    d0 = n_done; e0 = n_err;
    send(CMD_SET_LED);
    dev_frame(11, 1'b1, 1'b0, 8, rx, inh, both, sl, tmo);
    check("ed_request_seen", tmo, 0);
    check("ed_inhibit_len", inh, INH);
    check("ed_clk_low_with_start", both, 1);
    check("ed_start_bit", sl, 0);
    check("ed_frame_bits", rx, ref_frame(8'hED));
    step(20);
    check("ed_done_count", n_done - d0, 1);
    check("ed_err_count", n_err - e0, 0);
    check("ed_ready_after", tx_ready, 1);

    // Back-to-back 0x07 then 0x00, tx_valid held through the first frame.
    d0 = n_done; e0 = n_err;
    tx_data = 8'h07; tx_valid = 1'b1;
    step(1);
    tx_data = 8'h00;
    dev_frame(11, 1'b1, 1'b0, 8, rx, inh, both, sl, tmo);
    dev_frame(11, 1'b1, 1'b1, 8, rx2, inh, both, sl, tmo);
    check("b2b_second_request", tmo, 0);
    check("b2b_frame1_bits", rx, ref_frame(8'h07));
    check("b2b_frame1_parity", rx[8], 0);
    check("b2b_frame2_bits", rx2, ref_frame(8'h00));
    check("b2b_frame2_parity", rx2[8], 1);
    step(20);
    check("b2b_done_count", n_done - d0, 2);
    check("b2b_ready_after", tx_ready, 1);

    // Device never acks.
    d0 = n_done; e0 = n_err;
    b = 8'($urandom);
    send(b);
    dev_frame(11, 1'b0, 1'b0, 8, rx, inh, both, sl, tmo);
    check("nack_frame_bits", rx, ref_frame(b));
    step(20);
    check("nack_err_count", n_err - e0, 1);
    check("nack_done_count", n_done - d0, 0);
    check("nack_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);

    // Device never clocks: start timeout counted from clock release.
    e0 = n_err;
    send(CMD_ECHO);
    dev_frame(0, 1'b1, 1'b0, 8, rx, inh, both, sl, tmo);
    k = 0;
    while (!err && k < 400) begin step(1); k++; end
    check("start_tmo_cycles", k, STO);
    check("start_tmo_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    step(5);
    check("start_tmo_err_count", n_err - e0, 1);

    // Device stops after fall #5: frame timeout, then a clean reset command.
    d0 = n_done; e0 = n_err;
    b = 8'($urandom);
    send(b);
    dev_frame(5, 1'b1, 1'b0, 8, rx, inh, both, sl, tmo);
    k = 0;
    while (n_err == e0 && k < 600) begin step(1); k++; end
    step(2);
    check("frame_tmo_err_count", n_err - e0, 1);
    check("frame_tmo_done_count", n_done - d0, 0);
    check("frame_tmo_ready", tx_ready, 1);
    d0 = n_done;
    send(CMD_RESET);
    dev_frame(11, 1'b1, 1'b0, 8, rx, inh, both, sl, tmo);
    check("ff_frame_bits", rx, ref_frame(8'hFF));
    step(20);
    check("ff_done_count", n_done - d0, 1);

    // Reset while bit 3 (a zero) is on the line after fall #4.
    d0 = n_done; e0 = n_err;
    b = 8'($urandom) & 8'hF7;
    send(b);
    dev_frame(3, 1'b1, 1'b0, 8, rx, inh, both, sl, tmo);
    dev_clk = 1'b0;
    step(3);
    check("rst_mid_bit3_driven", ps2_data_oe, 1);
    rst = 1'b1;
    step(1);
    check("rst_mid_lines", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_mid_ready", tx_ready, 1);
    rst = 1'b0;
    dev_clk = 1'b1;
    step(30);
    check("rst_mid_no_pulse", {n_done - d0, n_err - e0}, 0);

    // Random commands and device clock rates.
    for (int i = 0; i < 4; i++) begin
      d0 = n_done; e0 = n_err;
      b = 8'($urandom);
      half = $urandom_range(4, 8);
      send(b);
      dev_frame(11, 1'b1, 1'b0, half, rx, inh, both, sl, tmo);
      check("rand_inhibit_len", inh, INH);
      check("rand_frame_bits", rx, ref_frame(b));
      step(20);
      check("rand_done_err", {n_done - d0, n_err - e0}, {32'd1, 32'd0});
    end

    check("done_err_overlap", n_both, 0);
    check("err_with_lines_driven", n_err_oe, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
